// File: rtl/beeb_bus_pkg.sv
// beeb_bus_pkg: shared types and constants for the Beeb bus arbiter.
// Bus states, owner tag, the bus request bundle and parked-bus values.
package beeb_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CPU_EXT = 2'd1,
    ST_DBG_EXT = 2'd2
  } bus_state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DBG = 1'b1
  } owner_t;

  typedef struct packed {
    logic [15:0] ab;
    logic        we;
    logic [7:0]  wdata;
  } bus_req_t;

  localparam logic [15:0] ADDR_SPEED        = 16'hFE38;
  localparam logic [15:0] ADDR_SYSVIA_LATCH = 16'hFE40;
  localparam logic [15:0] PARK_AB           = 16'hFFFF;
  localparam logic [7:0]  PARK_DO           = 8'hFF;

  localparam bus_req_t PARK_REQ = '{
    ab:    PARK_AB,
    we:    1'b0,
    wdata: PARK_DO
  };

  function automatic bus_req_t mk_req(
    input logic [15:0] ab,
    input logic        we,
    input logic [7:0]  wdata
  );
    bus_req_t r;
    r.ab    = ab;
    r.we    = we;
    r.wdata = wdata;
    return r;
  endfunction

endpackage

// File: rtl/beeb_phi_sync.sv
// beeb_phi_sync: PhiIn synchroniser/delay chain, Phi1/Phi2 outputs,
// cyc_end (falling edge of delayed Phi) and cyc_start (one clock later).
module beeb_phi_sync #(
  parameter int NPHI0_REGS = 5,
  parameter int PHIOUT_TAP = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic phi_in,
  output logic phi1_out,
  output logic phi2_out,
  output logic cyc_end,
  output logic cyc_start
);

  logic [NPHI0_REGS-1:0] phi_r;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      phi_r     <= '0;
      cyc_start <= 1'b0;
    end else begin
      phi_r     <= {phi_r[NPHI0_REGS-2:0], phi_in};
      cyc_start <= cyc_end;
    end
  end

  // Oldest sample high, next-oldest low: Phi0 has just fallen.
  assign cyc_end  = phi_r[NPHI0_REGS-1]
                  & ~phi_r[NPHI0_REGS-2];

  assign phi2_out = phi_r[PHIOUT_TAP];
  assign phi1_out = ~phi_r[PHIOUT_TAP];

endmodule

// File: rtl/beeb_bus_arbiter.sv
// beeb_bus_arbiter: shares the external Beeb bus between the 65C02 core
// and the debug master; owns core clken, speed divider and slowdown.
// Ports: clock/reset, phi_in -> phi1/phi2_out; cpu_* core side;
// dbg_* debug master (req/ack); bus_* pin-level bus; slow_active.
module beeb_bus_arbiter
  import beeb_bus_pkg::*;
#(
  parameter int NPHI0_REGS = 5,
  parameter int PHIOUT_TAP = 1,
  parameter int SLOW_SOUND = 15,
  parameter int SLOW_KBD   = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        phi_in,
  output logic        phi1_out,
  output logic        phi2_out,
  input  logic [15:0] cpu_ab,
  input  logic        cpu_we,
  input  logic [7:0]  cpu_do,
  input  logic        cpu_internal,
  output logic        cpu_clken,
  output logic [7:0]  cpu_rdata,
  input  logic        dbg_req,
  input  logic [15:0] dbg_ab,
  input  logic        dbg_we,
  input  logic [7:0]  dbg_do,
  output logic        dbg_ack,
  output logic [7:0]  dbg_rdata,
  input  logic [7:0]  bus_din,
  output logic [15:0] bus_ab,
  output logic        bus_we,
  output logic [7:0]  bus_do,
  output logic        slow_active
);

  logic       cyc_end;
  logic       cyc_start;

  bus_state_t state;
  bus_state_t nxt_state;
  owner_t     last_owner;
  bus_req_t   bus_r;
  bus_req_t   nxt_req;
  bus_req_t   cpu_bus;
  bus_req_t   dbg_bus;

  logic [5:0] cpu_div;
  logic [5:0] clk_div;
  logic [7:0] slowdown;

  logic cpu_wants;
  logic dbg_wants;
  logic tie;
  logic grant_cpu;
  logic grant_dbg;
  logic ext_cyc;
  logic rd_cap;
  logic fe40_wr;
  logic speed_wr;
  logic clken_nxt;

  beeb_phi_sync #(
    .NPHI0_REGS (NPHI0_REGS),
    .PHIOUT_TAP (PHIOUT_TAP)
  ) u_phi (
    .clock     (clock),
    .reset     (reset),
    .phi_in    (phi_in),
    .phi1_out  (phi1_out),
    .phi2_out  (phi2_out),
    .cyc_end   (cyc_end),
    .cyc_start (cyc_start)
  );

  assign cpu_bus = mk_req(cpu_ab, cpu_we, cpu_do);
  assign dbg_bus = mk_req(dbg_ab, dbg_we, dbg_do);

  // A requester whose access completes on this clock is not
  // re-granted: the core is advancing (clken high) and the debug
  // master is seeing its ack.
  assign cpu_wants = ~cpu_internal & ~cpu_clken;
  assign dbg_wants = dbg_req & ~dbg_ack;
  assign tie       = cpu_wants & dbg_wants;

  assign grant_cpu = cpu_wants
                   & (~dbg_wants | (last_owner == OWN_DBG));
  assign grant_dbg = dbg_wants & ~grant_cpu;

  always_comb begin
    nxt_state = ST_IDLE;
    nxt_req   = PARK_REQ;
    unique case (1'b1)
      grant_cpu: begin
        nxt_state = ST_CPU_EXT;
        nxt_req   = cpu_bus;
      end
      grant_dbg: begin
        nxt_state = ST_DBG_EXT;
        nxt_req   = dbg_bus;
      end
      default: begin
        nxt_state = ST_IDLE;
        nxt_req   = PARK_REQ;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      last_owner <= OWN_DBG;
      bus_r      <= PARK_REQ;
    end else if (cyc_start) begin
      state <= nxt_state;
      bus_r <= nxt_req;
      if (tie) begin
        last_owner <= grant_cpu ? OWN_CPU : OWN_DBG;
      end
    end
  end

  assign bus_ab = bus_r.ab;
  assign bus_we = bus_r.we;
  assign bus_do = bus_r.wdata;

  assign ext_cyc  = (state != ST_IDLE);
  assign rd_cap   = cyc_end & ext_cyc & ~bus_r.we;
  assign fe40_wr  = ext_cyc & bus_r.we
                  & (bus_r.ab == ADDR_SYSVIA_LATCH);
  assign speed_wr = (state == ST_CPU_EXT) & bus_r.we
                  & (bus_r.ab == ADDR_SPEED);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      clk_div <= '0;
    end else if (clk_div >= cpu_div) begin
      clk_div <= '0;
    end else begin
      clk_div <= clk_div + 6'd1;
    end
  end

  // Writing N to the speed register gives a period of N clocks;
  // N=0 wraps to the slowest setting (64).
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cpu_div <= '0;
    end else if (cyc_end && speed_wr) begin
      cpu_div <= bus_r.wdata[5:0] - 6'd1;
    end
  end

  // Sound writes (latch data[2:0]==0) need a long settle time,
  // other latch writes (keyboard etc.) only one Phi0 period.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      slowdown <= '0;
    end else if (cyc_end) begin
      if (fe40_wr) begin
        if (bus_r.wdata[2:0] == 3'd0) begin
          slowdown <= 8'(SLOW_SOUND);
        end else begin
          slowdown <= 8'(SLOW_KBD);
        end
      end else if (slowdown != '0) begin
        slowdown <= slowdown - 8'd1;
      end
    end
  end

  assign slow_active = (slowdown != '0);

  assign clken_nxt =
      (cpu_internal & (clk_div == '0) & (slowdown == '0)
       & (state != ST_CPU_EXT))
    | ((state == ST_CPU_EXT) & cyc_end);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cpu_clken <= 1'b0;
      dbg_ack   <= 1'b0;
      cpu_rdata <= 8'hFF;
      dbg_rdata <= 8'hFF;
    end else begin
      cpu_clken <= clken_nxt;
      dbg_ack   <= cyc_end & (state == ST_DBG_EXT);
      if (rd_cap && (state == ST_CPU_EXT)) begin
        cpu_rdata <= bus_din;
      end
      if (rd_cap && (state == ST_DBG_EXT)) begin
        dbg_rdata <= bus_din;
      end
    end
  end

endmodule
